// File: rtl/cpld_arb4_rr.sv
// rtl/cpld_arb4_rr.sv - 4-requester round-robin arbiter; hold-limit timeout compiled in by CPLD_ARB_TIMEOUT_EN
module cpld_arb4_rr #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [1:0] GID,
    output logic       BUSY,
    output logic       TOUT
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  gid_q, gid_d;
    logic [1:0]  last_q, last_d;
    logic        busy_q, busy_d;
    logic [1:0]  win;
    logic        win_vld;
    logic [1:0]  idx;
    logic        limit;

`ifdef CPLD_ARB_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        tout_q, tout_d;

    assign limit = (cnt_q == 8'(MAX_HOLD - 1));
    assign TOUT  = tout_q;
`else
    assign limit = 1'b0;
    assign TOUT  = 1'b0;
`endif

    // Rotating priority: LAST+1 is searched first, LAST itself last.
    always_comb begin
        win     = last_q;
        win_vld = 1'b0;
        idx     = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!win_vld && REQ[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gid_d   = gid_q;
        last_d  = last_q;
        busy_d  = busy_q;
`ifdef CPLD_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = OWN;
                    gnt_d   = 4'b0001 << win;
                    gid_d   = win;
                    last_d  = win;
                    busy_d  = 1'b1;
`ifdef CPLD_ARB_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end else begin
                    gnt_d  = 4'b0000;
                    busy_d = 1'b0;
                end
            end
            OWN: begin
                if (!REQ[gid_q] || limit) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                end
`ifdef CPLD_ARB_TIMEOUT_EN
                // TOUT only flags a revocation, not a voluntary release.
                tout_d = REQ[gid_q] && limit;
                cnt_d  = cnt_q + 8'd1;
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            gid_q   <= 2'd0;
            last_q  <= 2'd3;
            busy_q  <= 1'b0;
`ifdef CPLD_ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
`ifdef CPLD_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
`endif
        end
    end

    assign GNT  = gnt_q;
    assign GID  = gid_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_cpld_arb4_rr.sv
// tb/tb_cpld_arb4_rr.sv - self-checking bench for cpld_arb4_rr
module tb_cpld_arb4_rr;

    localparam int TB_MAX_HOLD = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] REQ = 4'b0000;
    logic [3:0] GNT;
    logic [1:0] GID;
    logic       BUSY;
    logic       TOUT;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int m_own  = -1;
    int m_gid  = 0;
    int m_last = 3;
    int m_hold = 0;
    int m_tout = 0;
    bit m_timeout_on;

    cpld_arb4_rr #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .CLK (CLK),
        .RST (RST),
        .REQ (REQ),
        .GNT (GNT),
        .GID (GID),
        .BUSY(BUSY),
        .TOUT(TOUT)
    );

    always #5 CLK = ~CLK;

`ifdef CPLD_ARB_TIMEOUT_EN
    initial m_timeout_on = 1'b1;
`else
    initial m_timeout_on = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = none), last winner, granted-cycle count.
    always @(posedge CLK) begin
        if (RST) begin
            m_own = -1; m_gid = 0; m_last = 3; m_hold = 0; m_tout = 0;
        end else begin
            m_tout = 0;
            if (m_own < 0) begin
                for (int i = 1; i <= 4; i++) begin
                    if (m_own < 0 && REQ[(m_last + i) % 4]) m_own = (m_last + i) % 4;
                end
                if (m_own >= 0) begin
                    m_gid = m_own; m_last = m_own; m_hold = 1;
                end
            end else if (!REQ[m_own]) begin
                m_own = -1;
            end else if (m_timeout_on && m_hold >= TB_MAX_HOLD) begin
                m_own = -1; m_tout = 1;
            end else begin
                m_hold++;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model_gnt", GNT, (m_own < 0) ? 0 : (1 << m_own));
            chk("model_gid", GID, m_gid);
            chk("model_busy", BUSY, (m_own >= 0) ? 1 : 0);
            chk("model_tout", TOUT, m_tout);
        end
    end

    logic [3:0] pat [8] = '{4'b1010, 4'b0110, 4'b1111, 4'b0000,
                            4'b1000, 4'b0101, 4'b0011, 4'b1110};

    initial begin
        RST = 1'b1;
        REQ = 4'b1111;
        @(posedge CLK);
        chk_en = 1'b1;
        @(negedge CLK); #2;
        chk("rst_gnt", GNT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_gid", GID, 0);
        chk("rst_tout", TOUT, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK); #2;
        chk("first_gnt", GNT, 4'b0001);
        chk("first_gid", GID, 0);

        // Round robin, each owner drops its bit after 3 granted cycles
        for (int k = 0; k < 4; k++) begin
            repeat (2) @(negedge CLK);
            REQ[k] = 1'b0;
            @(negedge CLK); #2;
            chk("rr_dead", GNT, 0);
            REQ = 4'b1111;
            @(negedge CLK); #2;
            chk("rr_grant", GNT, 1 << ((k + 1) % 4));
        end
        REQ = 4'b0000;
        @(negedge CLK); #2;
        chk("rr_release", GNT, 0);

        // Single requester for 5 cycles
        REQ = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK); #2;
            chk("single_gnt", GNT, 4'b0100);
            chk("single_gid", GID, 2);
        end
        REQ = 4'b0000;
        @(negedge CLK); #2;
        chk("single_rel", GNT, 0);
        chk("single_gid_hold", GID, 2);

        // Priority rotation after owner 2
        REQ = 4'b1001;
        @(negedge CLK); #2;
        chk("rot_gnt3", GNT, 4'b1000);
        REQ = 4'b0001;
        @(negedge CLK); #2;
        chk("rot_dead", GNT, 0);
        REQ = 4'b1001;
        @(negedge CLK); #2;
        chk("rot_gnt0", GNT, 4'b0001);

        // Reset mid-ownership
        REQ = 4'b0010;
        @(negedge CLK);
        @(negedge CLK); #2;
        chk("mid_gnt1", GNT, 4'b0010);
        RST = 1'b1;
        REQ = 4'b0011;
        @(negedge CLK); #2;
        chk("mid_rst_gnt", GNT, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_gid", GID, 0);
        RST = 1'b0;
        @(negedge CLK); #2;
        chk("mid_regrant", GNT, 4'b0001);

        // Hold-limit behaviour with REQ = 0011 held
`ifdef CPLD_ARB_TIMEOUT_EN
        for (int c = 1; c < TB_MAX_HOLD; c++) begin
            @(negedge CLK); #2;
            chk("to_hold", GNT, 4'b0001);
        end
        @(negedge CLK); #2;
        chk("to_dead", GNT, 0);
        chk("to_pulse", TOUT, 1);
        @(negedge CLK); #2;
        chk("to_next", GNT, 4'b0010);
        chk("to_pulse_end", TOUT, 0);
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK); #2;
            chk("hold_gnt", GNT, 4'b0001);
            chk("hold_tout", TOUT, 0);
        end
`endif

        // Pattern table, checked by the model each cycle
        for (int p = 0; p < 8; p++) begin
            REQ = pat[p];
            repeat (3) @(negedge CLK);
        end
        REQ = 4'b0000;
        repeat (3) @(negedge CLK);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
